// File: rtl/ahb_arb_pkg.sv
// Shared types for the two-master AHB-Lite arbiter: HTRANS encodings,
// master index and the packed address-phase record carried through the hold stages.
package ahb_arb_pkg;

    localparam int AHB_AW = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef logic mst_idx_t;

    typedef struct packed {
        logic [AHB_AW-1:0] addr;
        htrans_e           trans;
        logic              write;
        logic [2:0]        size;
        logic [2:0]        burst;
        logic [3:0]        prot;
        logic              lock;
    } addr_phase_t;

    localparam addr_phase_t ADDR_PHASE_RST = '0;

    // NONSEQ and SEQ are the only encodings that move data.
    function automatic logic is_active(input htrans_e t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_arb_hold.sv
// Per-master input stage: presents either the live or the held address phase,
// and latches a live request that was not issued so the master can be stalled.
module ahb_arb_hold
    import ahb_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  addr_phase_t live_ap,
    input  logic        hready_m,
    input  logic        issue,
    output logic        req,
    output logic        pending,
    output addr_phase_t ap
);

    addr_phase_t held_q;
    logic        pending_q;
    logic        live_req;

    // Nothing is requested while reset is asserted, so a held transfer can never leak out.
    assign live_req = is_active(live_ap.trans) && hready_m && !rst;
    assign req      = !rst && (pending_q ? is_active(held_q.trans) : live_req);
    assign ap       = pending_q ? held_q : live_ap;
    assign pending  = pending_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
            held_q    <= ADDR_PHASE_RST;
        end else if (issue) begin
            pending_q <= 1'b0;
        end else if (live_req) begin
            pending_q <= 1'b1;
            held_q    <= live_ap;
        end
    end

endmodule

// File: rtl/ahb_lite_arb2.sv
// Two-master AHB-Lite arbiter (M0 = processor, M1 = DMA/loader) in front of one slave path.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed priority to M0.
module ahb_lite_arb2
    import ahb_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic [AW-1:0] HADDR_M0,
    input  logic [1:0]    HTRANS_M0,
    input  logic          HWRITE_M0,
    input  logic [2:0]    HSIZE_M0,
    input  logic [2:0]    HBURST_M0,
    input  logic [3:0]    HPROT_M0,
    input  logic          HMASTLOCK_M0,
    input  logic [DW-1:0] HWDATA_M0,
    output logic [DW-1:0] HRDATA_M0,
    output logic          HREADY_M0,
    output logic          HRESP_M0,
    input  logic [AW-1:0] HADDR_M1,
    input  logic [1:0]    HTRANS_M1,
    input  logic          HWRITE_M1,
    input  logic [2:0]    HSIZE_M1,
    input  logic [2:0]    HBURST_M1,
    input  logic [3:0]    HPROT_M1,
    input  logic          HMASTLOCK_M1,
    input  logic [DW-1:0] HWDATA_M1,
    output logic [DW-1:0] HRDATA_M1,
    output logic          HREADY_M1,
    output logic          HRESP_M1,
    output logic [AW-1:0] HADDR_S,
    output logic [1:0]    HTRANS_S,
    output logic          HWRITE_S,
    output logic [2:0]    HSIZE_S,
    output logic [2:0]    HBURST_S,
    output logic [3:0]    HPROT_S,
    output logic          HMASTLOCK_S,
    output logic [DW-1:0] HWDATA_S,
    input  logic [DW-1:0] HRDATA_S,
    input  logic          HREADY_S,
    input  logic          HRESP_S,
    output logic          HMASTER
);

    addr_phase_t live_ap0, live_ap1, ap0, ap1, ap_g, ap_s, ap_last_q;
    logic        req0, req1, pend0, pend1, req_g, issue, issue0, issue1;
    logic        tie_winner, dph_valid_q, lock_q;
    mst_idx_t    grant, hmaster_q, dph_owner_q;

    assign live_ap0 = '{addr: AHB_AW'(HADDR_M0), trans: htrans_e'(HTRANS_M0), write: HWRITE_M0,
                        size: HSIZE_M0, burst: HBURST_M0, prot: HPROT_M0, lock: HMASTLOCK_M0};
    assign live_ap1 = '{addr: AHB_AW'(HADDR_M1), trans: htrans_e'(HTRANS_M1), write: HWRITE_M1,
                        size: HSIZE_M1, burst: HBURST_M1, prot: HPROT_M1, lock: HMASTLOCK_M1};

    // Handshake: a transfer is accepted by the slave in the cycle it is driven with
    // HTRANS_S active and HREADY_S high; a master sees its own address phase accepted
    // when HREADY_Mx is high, and a held (pending) master is stalled with HREADY_Mx low.
    assign HREADY_M0 = pend0 ? 1'b0 : ((dph_valid_q && dph_owner_q == 1'b0) ? HREADY_S : 1'b1);
    assign HREADY_M1 = pend1 ? 1'b0 : ((dph_valid_q && dph_owner_q == 1'b1) ? HREADY_S : 1'b1);
    assign HRESP_M0  = dph_valid_q && dph_owner_q == 1'b0 && HRESP_S;
    assign HRESP_M1  = dph_valid_q && dph_owner_q == 1'b1 && HRESP_S;
    assign HRDATA_M0 = HRDATA_S;
    assign HRDATA_M1 = HRDATA_S;
    assign HWDATA_S  = (dph_owner_q == 1'b1) ? HWDATA_M1 : HWDATA_M0;

    ahb_arb_hold u_hold0 (
        .clk(HCLK), .rst(HRESET), .live_ap(live_ap0), .hready_m(HREADY_M0),
        .issue(issue0), .req(req0), .pending(pend0), .ap(ap0)
    );

    ahb_arb_hold u_hold1 (
        .clk(HCLK), .rst(HRESET), .live_ap(live_ap1), .hready_m(HREADY_M1),
        .issue(issue1), .req(req1), .pending(pend1), .ap(ap1)
    );

`ifdef ARB_ROUND_ROBIN_EN
    mst_idx_t rr_last_q;

    assign tie_winner = ~rr_last_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rr_last_q <= 1'b0;
        end else if (issue) begin
            rr_last_q <= grant;
        end
    end
`else
    assign tie_winner = 1'b0;
`endif

    // Wait states and locked sequences keep the current owner; otherwise park on it when idle.
    always_comb begin
        grant = hmaster_q;
        if (HREADY_S && !lock_q) begin
            if (req0 && req1) begin
                grant = tie_winner;
            end else if (req0) begin
                grant = 1'b0;
            end else if (req1) begin
                grant = 1'b1;
            end
        end
    end

    assign req_g  = (grant == 1'b1) ? req1 : req0;
    assign ap_g   = (grant == 1'b1) ? ap1 : ap0;
    assign issue  = HREADY_S && req_g;
    assign issue0 = issue && grant == 1'b0;
    assign issue1 = issue && grant == 1'b1;

    // An idle bus repeats the parked owner's last issued fields; a SEQ that lost its
    // place in the burst to the other master restarts as NONSEQ.
    always_comb begin
        ap_s       = ap_last_q;
        ap_s.trans = HTRANS_IDLE;
        if (req_g) begin
            ap_s = ap_g;
            if (ap_g.trans == HTRANS_SEQ && grant != hmaster_q) begin
                ap_s.trans = HTRANS_NONSEQ;
            end
        end
    end

    assign HADDR_S     = AW'(ap_s.addr);
    assign HTRANS_S    = ap_s.trans;
    assign HWRITE_S    = ap_s.write;
    assign HSIZE_S     = ap_s.size;
    assign HBURST_S    = ap_s.burst;
    assign HPROT_S     = ap_s.prot;
    assign HMASTLOCK_S = ap_s.lock;
    assign HMASTER     = grant;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            hmaster_q   <= 1'b0;
            dph_owner_q <= 1'b0;
            dph_valid_q <= 1'b0;
            lock_q      <= 1'b0;
            ap_last_q   <= ADDR_PHASE_RST;
        end else if (HREADY_S) begin
            hmaster_q   <= grant;
            dph_valid_q <= issue;
            lock_q      <= issue && ap_g.lock;
            if (issue) begin
                dph_owner_q <= grant;
                ap_last_q   <= ap_s;
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_arb2.sv
// Directed bench for ahb_lite_arb2: the slave response is driven cycle by cycle and
// every expected value below is hand-derived; follows ARB_ROUND_ROBIN_EN if defined.
module tb_ahb_lite_arb2;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic        HCLK, HRESET;
    logic [31:0] HADDR_M0, HADDR_M1, HWDATA_M0, HWDATA_M1, HRDATA_M0, HRDATA_M1;
    logic [1:0]  HTRANS_M0, HTRANS_M1;
    logic        HWRITE_M0, HWRITE_M1, HMASTLOCK_M0, HMASTLOCK_M1;
    logic [2:0]  HSIZE_M0, HSIZE_M1, HBURST_M0, HBURST_M1;
    logic [3:0]  HPROT_M0, HPROT_M1;
    logic        HREADY_M0, HREADY_M1, HRESP_M0, HRESP_M1;
    logic [31:0] HADDR_S, HWDATA_S, HRDATA_S;
    logic [1:0]  HTRANS_S;
    logic        HWRITE_S, HMASTLOCK_S, HREADY_S, HRESP_S, HMASTER;
    logic [2:0]  HSIZE_S, HBURST_S;
    logic [3:0]  HPROT_S;

    int n_checks = 0;
    int n_fail   = 0;

    ahb_lite_arb2 #(.AW(32), .DW(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .HADDR_M0(HADDR_M0), .HTRANS_M0(HTRANS_M0), .HWRITE_M0(HWRITE_M0), .HSIZE_M0(HSIZE_M0),
        .HBURST_M0(HBURST_M0), .HPROT_M0(HPROT_M0), .HMASTLOCK_M0(HMASTLOCK_M0),
        .HWDATA_M0(HWDATA_M0), .HRDATA_M0(HRDATA_M0), .HREADY_M0(HREADY_M0), .HRESP_M0(HRESP_M0),
        .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1), .HWRITE_M1(HWRITE_M1), .HSIZE_M1(HSIZE_M1),
        .HBURST_M1(HBURST_M1), .HPROT_M1(HPROT_M1), .HMASTLOCK_M1(HMASTLOCK_M1),
        .HWDATA_M1(HWDATA_M1), .HRDATA_M1(HRDATA_M1), .HREADY_M1(HREADY_M1), .HRESP_M1(HRESP_M1),
        .HADDR_S(HADDR_S), .HTRANS_S(HTRANS_S), .HWRITE_S(HWRITE_S), .HSIZE_S(HSIZE_S),
        .HBURST_S(HBURST_S), .HPROT_S(HPROT_S), .HMASTLOCK_S(HMASTLOCK_S), .HWDATA_S(HWDATA_S),
        .HRDATA_S(HRDATA_S), .HREADY_S(HREADY_S), .HRESP_S(HRESP_S), .HMASTER(HMASTER)
    );

    // Clock and reset
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Driver tasks
    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_m(input int m, input logic [1:0] t, input logic [31:0] a,
                           input logic w, input logic l);
        if (m == 0) begin
            HTRANS_M0 = t; HADDR_M0 = a; HWRITE_M0 = w; HMASTLOCK_M0 = l;
        end else begin
            HTRANS_M1 = t; HADDR_M1 = a; HWRITE_M1 = w; HMASTLOCK_M1 = l;
        end
    endtask

    task automatic idle_both();
        drive_m(0, T_IDLE, 32'h0, 1'b0, 1'b0);
        drive_m(1, T_IDLE, 32'h0, 1'b0, 1'b0);
    endtask

    // Scoreboard check
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        HRESET = 1'b1;
        idle_both();
        HSIZE_M0 = 3'd2; HSIZE_M1 = 3'd2; HBURST_M0 = 3'd0; HBURST_M1 = 3'd0;
        HPROT_M0 = 4'h3; HPROT_M1 = 4'h3;
        HWDATA_M0 = 32'h0; HWDATA_M1 = 32'h0;
        HRDATA_S = 32'h0; HREADY_S = 1'b1; HRESP_S = 1'b0;
        repeat (2) cyc();
        HRESET = 1'b0;
        #1;
        check("rst_htrans", HTRANS_S, 0);
        check("rst_haddr", HADDR_S, 0);
        check("rst_hwrite", HWRITE_S, 0);
        check("rst_hmaster", HMASTER, 0);
        check("rst_hready_m0", HREADY_M0, 1);
        check("rst_hready_m1", HREADY_M1, 1);
        check("rst_hresp_m0", HRESP_M0, 0);
        check("rst_hresp_m1", HRESP_M1, 0);

        // Uncontended M0 read
        cyc(); drive_m(0, T_NONSEQ, 32'h0000_0100, 1'b0, 1'b0); #1;
        check("t1_haddr", HADDR_S, 32'h100);
        check("t1_htrans", HTRANS_S, T_NONSEQ);
        check("t1_hsize", HSIZE_S, 2);
        check("t1_hprot", HPROT_S, 3);
        check("t1_hmaster", HMASTER, 0);
        cyc(); idle_both(); HRDATA_S = 32'hCAFE_0001; #1;
        check("t1_hrdata_m0", HRDATA_M0, 32'hCAFE_0001);
        check("t1_hready_m0", HREADY_M0, 1);
        check("t1_hready_m1", HREADY_M1, 1);

        // Simultaneous requests
        cyc();
        drive_m(0, T_NONSEQ, 32'h0000_0104, 1'b0, 1'b0);
        drive_m(1, T_NONSEQ, 32'h2000_0000, 1'b1, 1'b0);
        #1;
`ifdef ARB_ROUND_ROBIN_EN
        check("t2_hmaster", HMASTER, 1);
        check("t2_haddr", HADDR_S, 32'h2000_0000);
        check("t2_hready_m0", HREADY_M0, 1);
`else
        check("t2_hmaster", HMASTER, 0);
        check("t2_haddr", HADDR_S, 32'h104);
        check("t2_hready_m1", HREADY_M1, 1);
`endif
        cyc(); idle_both(); HWDATA_M1 = 32'h1234_5678; HRDATA_S = 32'hCAFE_0002; #1;
`ifdef ARB_ROUND_ROBIN_EN
        check("t2_hwdata_s", HWDATA_S, 32'h1234_5678);
        check("t2_hready_m0_stall", HREADY_M0, 0);
        check("t2_hmaster2", HMASTER, 0);
        check("t2_haddr2", HADDR_S, 32'h104);
`else
        check("t2_hready_m1_stall", HREADY_M1, 0);
        check("t2_hmaster2", HMASTER, 1);
        check("t2_haddr2", HADDR_S, 32'h2000_0000);
        check("t2_hwrite2", HWRITE_S, 1);
        check("t2_hrdata_m0", HRDATA_M0, 32'hCAFE_0002);
        check("t2_hready_m0", HREADY_M0, 1);
`endif
        cyc(); #1;
`ifdef ARB_ROUND_ROBIN_EN
        check("t2_hready_m0_done", HREADY_M0, 1);
        check("t2_hrdata_m0", HRDATA_M0, 32'hCAFE_0002);
`else
        check("t2_hwdata_s", HWDATA_S, 32'h1234_5678);
        check("t2_hready_m1_done", HREADY_M1, 1);
`endif
        check("t2_htrans_idle", HTRANS_S, T_IDLE);

        // Locked M1 sequence with M0 contending
        cyc(); drive_m(1, T_NONSEQ, 32'h3000_0000, 1'b0, 1'b1); #1;
        check("t3_hmaster_a", HMASTER, 1);
        check("t3_hmastlock", HMASTLOCK_S, 1);
        cyc();
        drive_m(1, T_SEQ, 32'h3000_0004, 1'b0, 1'b1);
        drive_m(0, T_NONSEQ, 32'h0000_0200, 1'b0, 1'b0);
        #1;
        check("t3_hmaster_b", HMASTER, 1);
        check("t3_haddr_b", HADDR_S, 32'h3000_0004);
        check("t3_htrans_seq", HTRANS_S, T_SEQ);
        cyc();
        drive_m(1, T_SEQ, 32'h3000_0008, 1'b0, 1'b1);
        drive_m(0, T_IDLE, 32'h0, 1'b0, 1'b0);
        #1;
        check("t3_hmaster_c", HMASTER, 1);
        check("t3_haddr_c", HADDR_S, 32'h3000_0008);
        check("t3_hready_m0_stall", HREADY_M0, 0);
        cyc(); idle_both(); #1;
        check("t3_htrans_unlock", HTRANS_S, T_IDLE);
        check("t3_hmaster_unlock", HMASTER, 1);
        check("t3_hready_m0_wait", HREADY_M0, 0);
        cyc(); #1;
        check("t3_hmaster_m0", HMASTER, 0);
        check("t3_haddr_m0", HADDR_S, 32'h200);
        check("t3_htrans_m0", HTRANS_S, T_NONSEQ);
        cyc(); #1;
        check("t3_hready_m0_done", HREADY_M0, 1);

        // Wait states and two-cycle ERROR to M0, held M1 transfer afterwards
        cyc(); drive_m(0, T_NONSEQ, 32'h0000_0400, 1'b1, 1'b0); #1;
        check("t4_hmaster", HMASTER, 0);
        check("t4_haddr", HADDR_S, 32'h400);
        cyc();
        drive_m(0, T_IDLE, 32'h0, 1'b0, 1'b0);
        HWDATA_M0 = 32'hDEAD_0400;
        drive_m(1, T_NONSEQ, 32'h0000_0500, 1'b0, 1'b0);
        HREADY_S = 1'b0;
        #1;
        check("t4_w1_hready_m0", HREADY_M0, 0);
        check("t4_w1_hready_m1", HREADY_M1, 1);
        check("t4_w1_htrans", HTRANS_S, T_IDLE);
        check("t4_w1_hwdata", HWDATA_S, 32'hDEAD_0400);
        cyc(); drive_m(1, T_IDLE, 32'h0, 1'b0, 1'b0); #1;
        check("t4_w2_hready_m1", HREADY_M1, 0);
        check("t4_w2_htrans", HTRANS_S, T_IDLE);
        check("t4_w2_hmaster", HMASTER, 0);
        cyc(); HRESP_S = 1'b1; #1;
        check("t4_e1_hresp_m0", HRESP_M0, 1);
        check("t4_e1_hresp_m1", HRESP_M1, 0);
        check("t4_e1_hready_m0", HREADY_M0, 0);
        cyc(); HREADY_S = 1'b1; #1;
        check("t4_e2_hresp_m0", HRESP_M0, 1);
        check("t4_e2_hready_m0", HREADY_M0, 1);
        check("t4_e2_hresp_m1", HRESP_M1, 0);
        check("t4_e2_hmaster", HMASTER, 1);
        check("t4_e2_haddr", HADDR_S, 32'h500);
        cyc(); HRESP_S = 1'b0; HRDATA_S = 32'hCAFE_0005; #1;
        check("t4_hrdata_m1", HRDATA_M1, 32'hCAFE_0005);
        check("t4_hready_m1", HREADY_M1, 1);
        check("t4_hresp_m0_clr", HRESP_M0, 0);

        // Reset while M1 is pending
        cyc();
        drive_m(0, T_NONSEQ, 32'h0000_0600, 1'b0, 1'b0);
        drive_m(1, T_NONSEQ, 32'h0000_0700, 1'b1, 1'b0);
        #1;
        check("t5_hmaster", HMASTER, 0);
        check("t5_haddr", HADDR_S, 32'h600);
        cyc(); idle_both(); HRESET = 1'b1; #1;
        check("t5_rst_htrans", HTRANS_S, T_IDLE);
        cyc(); HRESET = 1'b0; #1;
        check("t5_post_htrans", HTRANS_S, T_IDLE);
        check("t5_post_hready_m0", HREADY_M0, 1);
        check("t5_post_hready_m1", HREADY_M1, 1);
        check("t5_post_hmaster", HMASTER, 0);
        check("t5_post_haddr", HADDR_S, 0);

        // Held SEQ reissued as NONSEQ after the other master took the bus
        cyc(); drive_m(1, T_NONSEQ, 32'h0000_0900, 1'b0, 1'b0); #1;
        check("t6_hmaster_a", HMASTER, 1);
        check("t6_haddr_a", HADDR_S, 32'h900);
        check("t6_htrans_a", HTRANS_S, T_NONSEQ);
        cyc();
        drive_m(1, T_SEQ, 32'h0000_0904, 1'b0, 1'b0);
        drive_m(0, T_NONSEQ, 32'h0000_0A00, 1'b0, 1'b0);
        #1;
        check("t6_hmaster_b", HMASTER, 0);
        check("t6_haddr_b", HADDR_S, 32'hA00);
        cyc(); idle_both(); #1;
        check("t6_hmaster_c", HMASTER, 1);
        check("t6_haddr_c", HADDR_S, 32'h904);
        check("t6_htrans_c", HTRANS_S, T_NONSEQ);
        check("t6_hready_m1_stall", HREADY_M1, 0);
        cyc(); #1;
        check("t6_hready_m1_done", HREADY_M1, 1);
        check("t6_htrans_idle", HTRANS_S, T_IDLE);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
